// File: rtl/rotator_sequencer.sv
// rtl/rotator_sequencer.sv - command FIFO plus sequencer expanding load/rotate commands into rotator strobes

module rotator_sequencer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_ready,
    output logic          o_empty,
    output logic          o_empty_nxt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;

    // ready only reflects fullness; a same-cycle pop does not open a slot early
    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && (r_count != '0);

    // occupancy after this edge
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // pointers, occupancy and registered ready flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CNT_FULL);
        end
    end

    // entry storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_ready     = r_ready;
    assign o_empty     = (r_count == '0);
    assign o_empty_nxt = (w_count_nxt == '0);

endmodule

module rotator_sequencer #(
    parameter int WIDTH      = 100,
    parameter int AMT_W      = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rot_load,
    output logic [WIDTH-1:0] rot_data,
    output logic [1:0]       rot_en,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] offset
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam int EW = 2 + AMT_W + WIDTH;
    // one extra bit so WIDTH == 2**AMT_W is still representable as a modulus
    localparam logic [AMT_W:0]   WIDTH_MOD = (AMT_W + 1)'(WIDTH);
    localparam logic [AMT_W-1:0] OFF_MAX   = AMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic             r_rot_load;
    logic             w_rot_load_nxt;
    logic [WIDTH-1:0] r_rot_data;
    logic [WIDTH-1:0] w_rot_data_nxt;
    logic [1:0]       r_rot_en;
    logic [1:0]       w_rot_en_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [AMT_W-1:0] r_offset;
    logic [AMT_W-1:0] w_offset_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    logic [EW-1:0]    w_head;
    logic [1:0]       w_head_op;
    logic [AMT_W-1:0] w_head_amt;
    logic [WIDTH-1:0] w_head_data;
    logic [AMT_W-1:0] w_head_steps;
    logic             w_empty;
    logic             w_empty_nxt;
    logic             w_pop;
    logic             w_fifo_ready;

    // one rotation step of the net offset, wrapping at WIDTH in both directions
    function automatic logic [AMT_W-1:0] f_step(input logic [1:0] dir, input logic [AMT_W-1:0] off);
        logic [AMT_W-1:0] res;
        res = off;
        if (dir == OP_LEFT) begin
            res = (off == OFF_MAX) ? '0 : off + AMT_W'(1);
        end else if (dir == OP_RIGHT) begin
            res = (off == '0) ? OFF_MAX : off - AMT_W'(1);
        end
        return res;
    endfunction

    rotator_sequencer_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (cmd_valid),
        .i_data      ({cmd_op, cmd_amt, cmd_data}),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_ready     (w_fifo_ready),
        .o_empty     (w_empty),
        .o_empty_nxt (w_empty_nxt)
    );

    assign {w_head_op, w_head_amt, w_head_data} = w_head;
    assign w_head_steps = AMT_W'({1'b0, w_head_amt} % WIDTH_MOD);
    assign w_pop        = (r_state == S_IDLE) && !w_empty;

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state: zero-length commands skip EXEC so done follows the pop directly
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    if (w_head_op == OP_LOAD) begin
                        w_state_nxt = S_EXEC;
                    end else if (((w_head_op == OP_LEFT) || (w_head_op == OP_RIGHT)) &&
                                 (w_head_steps != '0)) begin
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // next registered outputs; r_cnt holds steps still owed after the current one
    always_comb begin
        w_op_nxt       = r_op;
        w_cnt_nxt      = r_cnt;
        w_rot_load_nxt = 1'b0;
        w_rot_data_nxt = r_rot_data;
        w_rot_en_nxt   = 2'b00;
        w_done_nxt     = 1'b0;
        w_offset_nxt   = r_offset;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_op_nxt  = w_head_op;
                    w_cnt_nxt = '0;
                    case (w_head_op)
                        OP_LOAD: begin
                            w_rot_load_nxt = 1'b1;
                            w_rot_data_nxt = w_head_data;
                            w_offset_nxt   = '0;
                        end
                        OP_LEFT, OP_RIGHT: begin
                            if (w_head_steps != '0) begin
                                w_rot_en_nxt = w_head_op;
                                w_offset_nxt = f_step(w_head_op, r_offset);
                                w_cnt_nxt    = w_head_steps - AMT_W'(1);
                            end else begin
                                w_done_nxt = 1'b1;
                            end
                        end
                        default: w_done_nxt = 1'b1;
                    endcase
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_rot_en_nxt = r_op;
                    w_offset_nxt = f_step(r_op, r_offset);
                    w_cnt_nxt    = r_cnt - AMT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // busy looks ahead so it rises on the same edge a command is accepted
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE) || !w_empty_nxt;
    end

    // output and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op       <= OP_NOP;
            r_cnt      <= '0;
            r_rot_load <= 1'b0;
            r_rot_data <= '0;
            r_rot_en   <= 2'b00;
            r_done     <= 1'b0;
            r_offset   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_op       <= w_op_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rot_load <= w_rot_load_nxt;
            r_rot_data <= w_rot_data_nxt;
            r_rot_en   <= w_rot_en_nxt;
            r_done     <= w_done_nxt;
            r_offset   <= w_offset_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign cmd_ready = w_fifo_ready;
    assign rot_load  = r_rot_load;
    assign rot_data  = r_rot_data;
    assign rot_en    = r_rot_en;
    assign done      = r_done;
    assign offset    = r_offset;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rotator_sequencer.sv
// tb/tb_rotator_sequencer.sv - directed table-driven bench for rotator_sequencer

module tb_rotator_sequencer;

    localparam int WIDTH      = 100;
    localparam int AMT_W      = 7;
    localparam int FIFO_DEPTH = 2;

    logic             clk;
    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             rot_load;
    logic [WIDTH-1:0] rot_data;
    logic [1:0]       rot_en;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] offset;

    rotator_sequencer #(
        .WIDTH      (WIDTH),
        .AMT_W      (AMT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .rot_load  (rot_load),
        .rot_data  (rot_data),
        .rot_en    (rot_en),
        .busy      (busy),
        .done      (done),
        .offset    (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] data;
        int               exp_en;
        bit               exp_load;
        logic [AMT_W-1:0] exp_off;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    int n_accept = 0;
    int n_done   = 0;
    int en_since = 0;
    logic prev_done = 1'b0;
    int               done_cyc   [$];
    int               done_steps [$];
    logic [AMT_W-1:0] done_off   [$];
    logic [WIDTH-1:0] done_data  [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AMT_W-1:0] model_step(input logic [1:0] dir, input logic [AMT_W-1:0] off);
        int o;
        o = int'(off);
        if (dir == 2'b01) o = (o + 1) % WIDTH;
        else if (dir == 2'b10) o = (o + WIDTH - 1) % WIDTH;
        return AMT_W'(o);
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input int amt, input logic [WIDTH-1:0] data,
                                input int en, input bit ld, input int off, input logic [WIDTH-1:0] ed);
        vec_t v;
        v.op       = op;
        v.amt      = AMT_W'(amt);
        v.data     = data;
        v.exp_en   = en;
        v.exp_load = ld;
        v.exp_off  = AMT_W'(off);
        v.exp_data = ed;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // protocol invariants plus a log of every completed command
    always @(negedge clk) begin
        if (mon_en) begin
            if (resetn && cmd_valid && cmd_ready) n_accept++;
            check("inv_rot_en_11", (rot_en == 2'b11), 1'b0);
            check("inv_done_twice", (prev_done && done), 1'b0);
            check("inv_load_with_en", (rot_load && (rot_en != 2'b00)), 1'b0);
            if (rot_en != 2'b00) en_since++;
            if (done) begin
                n_done++;
                done_cyc.push_back(cyc);
                done_steps.push_back(en_since);
                done_off.push_back(offset);
                done_data.push_back(rot_data);
                en_since = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick;
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_vec(input int i, input vec_t v, input logic [AMT_W-1:0] start_off);
        int en_cnt, n_load, load_c, done_c, first_en, last_en, exp_done;
        bit dir_ok;
        logic [AMT_W-1:0] cur;
        en_cnt = 0; n_load = 0; load_c = -1; done_c = -1; first_en = -1; last_en = -1;
        dir_ok = 1; cur = start_off;
        exp_done = v.exp_load ? 2 : v.exp_en + 1;
        wait_idle($sformatf("v%0d", i));
        cmd_valid = 1'b1; cmd_op = v.op; cmd_amt = v.amt; cmd_data = v.data;
        tick;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 200 && done_c < 0; c++) begin
            tick;
            if (rot_en != 2'b00) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
                last_en = c;
                if (rot_en != v.op) dir_ok = 0;
                cur = model_step(v.op, cur);
                check($sformatf("v%0d_step_off_c%0d", i, c), offset, cur);
            end
            if (rot_load) begin
                n_load++;
                load_c = c;
                check($sformatf("v%0d_load_data", i), rot_data, v.data);
            end
            if (done) done_c = c;
        end
        check($sformatf("v%0d_en_count", i), en_cnt, v.exp_en);
        check($sformatf("v%0d_en_dir", i), dir_ok, 1'b1);
        if (v.exp_en > 0) begin
            check($sformatf("v%0d_first_en", i), first_en, 1);
            check($sformatf("v%0d_en_contig", i), last_en - first_en + 1, v.exp_en);
        end
        check($sformatf("v%0d_load_count", i), n_load, v.exp_load ? 1 : 0);
        if (v.exp_load) check($sformatf("v%0d_load_cycle", i), load_c, 1);
        check($sformatf("v%0d_done_cycle", i), done_c, exp_done);
        check($sformatf("v%0d_offset", i), offset, v.exp_off);
        check($sformatf("v%0d_rot_data", i), rot_data, v.exp_data);
        tick;
        check($sformatf("v%0d_done_drop", i), done, 1'b0);
        check($sformatf("v%0d_busy_drop", i), busy, 1'b0);
    endtask

    initial begin
        vec_t vecs [12];
        logic [WIDTH-1:0] ones;
        logic [AMT_W-1:0] prev_off;
        int acc0, done0, base, bound, en_seen;

        ones = '1;
        vecs[0]  = mk(2'b11,   0, 100'h1,       0, 1,  0, 100'h1);
        vecs[1]  = mk(2'b01,   3, '0,           3, 0,  3, 100'h1);
        vecs[2]  = mk(2'b11,   9, 100'hABCDEF,  0, 1,  0, 100'hABCDEF);
        vecs[3]  = mk(2'b01,   2, '0,           2, 0,  2, 100'hABCDEF);
        vecs[4]  = mk(2'b10,   5, '0,           5, 0, 97, 100'hABCDEF);
        vecs[5]  = mk(2'b01, 100, '0,           0, 0, 97, 100'hABCDEF);
        vecs[6]  = mk(2'b01,   0, '0,           0, 0, 97, 100'hABCDEF);
        vecs[7]  = mk(2'b01, 105, '0,           5, 0,  2, 100'hABCDEF);
        vecs[8]  = mk(2'b00,   7, 100'h55,      0, 0,  2, 100'hABCDEF);
        vecs[9]  = mk(2'b10, 127, '0,          27, 0, 75, 100'hABCDEF);
        vecs[10] = mk(2'b01,  26, '0,          26, 0,  1, 100'hABCDEF);
        vecs[11] = mk(2'b11,   0, ones,         0, 1,  0, ones);

        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_amt = '0; cmd_data = '0;
        repeat (3) tick;
        resetn = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rot_en", rot_en, 2'b00);
        check("rst_rot_load", rot_load, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_offset", offset, '0);
        check("rst_rot_data", rot_data, '0);
        mon_en = 1;

        prev_off = '0;
        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i], prev_off);
            prev_off = vecs[i].exp_off;
        end

        // back-to-back: three pushes fill the two-entry FIFO, a fourth waits
        wait_idle("b_start");
        acc0 = n_accept; done0 = n_done; base = done_cyc.size();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_amt = 7'd4; cmd_data = '0;
        tick;
        cmd_op = 2'b10; cmd_amt = 7'd1;
        tick;
        cmd_op = 2'b11; cmd_amt = 7'd0; cmd_data = 100'h5;
        tick;
        check("b_ready_full", cmd_ready, 1'b0);
        check("b_accepts_3", n_accept - acc0, 3);
        cmd_op = 2'b01; cmd_amt = 7'd1; cmd_data = '0;
        bound = 0;
        while (!cmd_ready && bound < 50) begin
            tick;
            bound++;
        end
        check("b_full_cycles", bound, 5);
        tick;
        cmd_valid = 1'b0;
        wait_idle("b_end");
        check("b_accepts_4", n_accept - acc0, 4);
        check("b_dones_4", n_done - done0, 4);
        if (done_cyc.size() >= base + 4) begin
            check("b_off_0", done_off[base],     7'd4);
            check("b_off_1", done_off[base + 1], 7'd3);
            check("b_off_2", done_off[base + 2], 7'd0);
            check("b_off_3", done_off[base + 3], 7'd1);
            check("b_steps_0", done_steps[base],     4);
            check("b_steps_1", done_steps[base + 1], 1);
            check("b_steps_2", done_steps[base + 2], 0);
            check("b_steps_3", done_steps[base + 3], 1);
            check("b_data_1", done_data[base + 1], ones);
            check("b_data_2", done_data[base + 2], 100'h5);
            check("b_gap_1", done_cyc[base + 1] - done_cyc[base],     3);
            check("b_gap_2", done_cyc[base + 2] - done_cyc[base + 1], 3);
            check("b_gap_3", done_cyc[base + 3] - done_cyc[base + 2], 3);
        end else begin
            check("b_done_log", done_cyc.size() - base, 4);
        end

        // reset on step 2 of a 6-step rotate, with a second command queued
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_amt = 7'd6;
        tick;
        cmd_amt = 7'd2;
        tick;
        cmd_valid = 1'b0;
        check("c_step1_en", rot_en, 2'b01);
        tick;
        check("c_step2_en", rot_en, 2'b01);
        check("c_step2_off", offset, 7'd3);
        done0 = n_done;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        check("c_rst_en", rot_en, 2'b00);
        check("c_rst_off", offset, '0);
        check("c_rst_busy", busy, 1'b0);
        check("c_rst_done", done, 1'b0);
        check("c_rst_ready", cmd_ready, 1'b1);
        check("c_rst_data", rot_data, '0);
        en_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (rot_en != 2'b00 || busy) en_seen++;
        end
        check("c_flushed_quiet", en_seen, 0);
        check("c_no_done", n_done - done0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
